// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: multi-cycle mult/multu/div/divu with a fixed
// busy window, plus single-cycle mthi/mtlo writes and an mfhi/mflo read port.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        we,
  input  logic        sel_hi,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  state_e         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  op_e            op_q;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_b;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_wr;

  assign busy = (state == BUSY);
  assign out  = sel_hi ? hi : lo;

  // Products are formed at full 64-bit width from the latched operands; the
  // signed form sign-extends both operands so the low 64 bits are exact.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // A zero divisor is swapped for 1 so the divider never sees x/0; the
  // result is discarded in that case anyway.
  assign div_b  = (b_q == '0) ? 32'd1 : b_q;
  assign quot_s = $signed(a_q) / $signed(div_b);
  assign rem_s  = $signed(a_q) % $signed(div_b);
  assign quot_u = a_q / div_b;
  assign rem_u  = a_q % div_b;

  // Select the HI/LO result for the latched operation and whether to commit it.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    res_wr = 1'b0;
    case (op_q)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_wr = 1'b1; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_wr = 1'b1; end
      OP_DIV:   begin res_hi = rem_s;         res_lo = quot_s;       res_wr = (b_q != '0); end
      OP_DIVU:  begin res_hi = rem_u;         res_lo = quot_u;       res_wr = (b_q != '0); end
      default:  res_wr = 1'b0;
    endcase
  end

  // Control FSM, operand latches, busy counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_MULT;
    end else begin
      case (state)
        IDLE: begin
          if (start && !op[2]) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op_e'(op);
            cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state <= BUSY;
          end else if (we && op_e'(op) == OP_MTHI) begin
            hi <= A;
          end else if (we && op_e'(op) == OP_MTLO) begin
            lo <= A;
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            if (res_wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed HI/LO results.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        we;
  logic        sel_hi;
  logic        busy;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .we     (we),
    .sel_hi (sel_hi),
    .busy   (busy),
    .out    (out),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles until busy falls, bounded so a stuck unit still ends.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_lo;
    int cycles;
    old_lo = lo;
    sel_hi = 1'b0;
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    A = 32'hA5A5_A5A5;
    B = 32'h5A5A_5A5A;
    check_val({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
    check_val({tag, "_out_old"}, out, old_lo);
    wait_idle(cycles);
    check_val({tag, "_cycles"}, cycles, n);
    check_val({tag, "_hi"}, hi, exp_hi);
    check_val({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic write_reg(input logic [2:0] o, input logic [31:0] a);
    op = o; A = a; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    int cycles;
    reset = 1'b1; start = 1'b0; we = 1'b0; op = 3'd7;
    A = '0; B = '0; sel_hi = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    check_val("rst_out", out, 32'd0);

    run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  3'd3, 32'd7,         32'd2, 10, 32'd1,         32'd3);

    write_reg(3'd4, 32'h11);
    write_reg(3'd5, 32'h22);
    check_val("mthi", hi, 32'h11);
    check_val("mtlo", lo, 32'h22);
    run_op("div0", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);

    write_reg(3'd4, 32'hDEAD_BEEF);
    sel_hi = 1'b1;
    #1;
    check_val("out_hi", out, 32'hDEAD_BEEF);
    sel_hi = 1'b0;
    #1;
    check_val("out_lo", out, 32'h22);

    // Inert encodings: start with op 4..7, we with op 0..3 or 6..7.
    op = 3'd4; A = 32'h123; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_op4_busy", {31'd0, busy}, 32'd0);
    check_val("start_op4_hi", hi, 32'hDEAD_BEEF);
    write_reg(3'd0, 32'h999);
    write_reg(3'd6, 32'h777);
    check_val("we_inert_hi", hi, 32'hDEAD_BEEF);
    check_val("we_inert_lo", lo, 32'h22);
    check_val("we_inert_busy", {31'd0, busy}, 32'd0);

    // mtlo issued while busy must be dropped.
    op = 3'd1; A = 32'd2; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    op = 3'd5; A = 32'h55; we = 1'b1;
    wait_idle(cycles);
    we = 1'b0;
    check_val("mtlo_busy_cycles", cycles, 5);
    check_val("mtlo_busy_hi", hi, 32'd0);
    check_val("mtlo_busy_lo", lo, 32'd6);
    tick();
    check_val("mtlo_busy_lo_after", lo, 32'd6);

    // start held through busy with churning operands: first op only.
    op = 3'd0; A = 32'd4; B = 32'd5; start = 1'b1;
    tick();
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      op = 3'(cycles % 4);
      A = $urandom;
      B = $urandom;
      tick();
    end
    start = 1'b0;
    check_val("restart_cycles", cycles, 5);
    check_val("restart_hi", hi, 32'd0);
    check_val("restart_lo", lo, 32'd20);
    tick();
    check_val("restart_idle", {31'd0, busy}, 32'd0);

    // Reset lands on the third busy cycle of a mult.
    op = 3'd0; A = 32'd7; B = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_hi", hi, 32'd0);
    check_val("midrst_lo", lo, 32'd0);
    repeat (6) tick();
    check_val("midrst_hi_late", hi, 32'd0);
    check_val("midrst_lo_late", lo, 32'd0);
    check_val("midrst_busy_late", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  EX-stage instruction is mult/multu/div/divu; qualified by op.
REQ-006 op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
REQ-007 A  input  32  forwarded rs operand from EX.
REQ-008 B  input  32  forwarded rt operand from EX.
REQ-009 we  input  1  EX instruction is mthi/mtlo; qualified by op.
REQ-010 sel_hi  input  1  read select: 1 HI, 0 LO (mfhi/mflo).
REQ-011 busy  output  1  operation in progress; registered.
REQ-012 out  output  32  sel_hi ? HI : LO, combinational from HI/LO registers; feeds EX result mux toward EX/MEM.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 States IDLE and BUSY; busy SHALL equal (state==BUSY).
REQ-016 In IDLE, start with op 0..3 on a rising edge SHALL latch A, B, op, load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3), and enter BUSY.
REQ-017 In BUSY, counter SHALL decrement each edge; at the edge where counter reaches 1, HI/LO SHALL be written and state SHALL return to IDLE.
REQ-018 Result visibility: start accepted at edge t -> busy high for exactly N cycles (t+1..t+N), HI/LO updated at edge t+N, busy low after t+N.
REQ-019 mult: {HI,LO} = signed(A)*signed(B), 64-bit; multu: unsigned 64-bit product.
REQ-020 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-021 Divide by zero (latched B == 0, op 2/3): full busy duration still elapses; HI/LO SHALL remain unchanged.
REQ-022 In IDLE, we with op 4 SHALL write HI <= A; op 5 SHALL write LO <= A, at that edge; no busy.
REQ-023 start or we while BUSY SHALL be ignored (external stall logic holds those instructions in EX while busy|start).
REQ-024 start and we together in IDLE: start SHALL take priority; we ignored.
REQ-025 start with op 4..7, or we with op 0..3 or 6..7, SHALL have no effect.
REQ-026 Operand changes on A/B during BUSY SHALL not affect the result (latched copies used).
REQ-027 out SHALL reflect the pre-update HI/LO during BUSY (consumer must stall).
REQ-028 Counter width SHALL hold max(MULT_CYCLES,DIV_CYCLES); parameters >= 1.

Reset
REQ-029 reset high at an edge SHALL force IDLE, busy=0, counter=0, HI=0, LO=0, regardless of state; an in-flight operation is abandoned, no HI/LO write.
REQ-030 Initial power-up values SHALL match reset values.

Verification
REQ-031 mult A=0xFFFFFFFE (-2), B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-033 HI=0x11, LO=0x22, divu B=0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
REQ-034 mthi A=0xDEADBEEF then sel_hi=1 -> out=0xDEADBEEF next cycle; mtlo during BUSY -> LO unchanged.
REQ-035 mult started, reset asserted on 3rd busy cycle -> next cycle busy=0, HI=LO=0, no later write.
REQ-036 start asserted every cycle during BUSY with changing A/B -> only first operation completes; result from first operands; busy exactly N cycles.
